// File: rtl/decode_queue.sv
// decode_queue: RV32I decoder feeding a DEPTH-entry FIFO of decoded micro-ops.
// Optional M-extension decode enabled by defining DECODE_QUEUE_MEXT_EN.
`default_nettype none

package decode_queue_pkg;
  typedef enum logic [5:0] {
    OP_NO_OP  = 6'd0,
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_ECALL, OP_EBREAK,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } opcode_e;
endpackage

module decode_queue #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_clk_en,
  input  logic                         i_flush,
  input  logic                         i_inst_valid,
  output logic                         o_inst_ready,
  input  logic [31:0]                  i_inst,
  input  logic [AW-1:0]                i_pc,
  output logic                         o_valid,
  input  logic                         i_ready,
  output decode_queue_pkg::opcode_e    o_opcode,
  output logic [4:0]                   o_rs1,
  output logic [4:0]                   o_rs2,
  output logic [4:0]                   o_rd,
  output logic [DW-1:0]                o_imm,
  output logic [AW-1:0]                o_pc,
  output logic                         o_illegal,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);
  import decode_queue_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [PW-1:0] C_PTR_ONE = PW'(1);
  localparam logic [CW-1:0] C_CNT_ONE = CW'(1);
  localparam logic [CW-1:0] C_FULL    = CW'(DEPTH);

  typedef struct packed {
    opcode_e       op;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [4:0]    rd;
    logic [DW-1:0] imm;
    logic [AW-1:0] pc;
    logic          illegal;
  } entry_t;

  logic [6:0]  w_major;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_j, w_imm_u;
  opcode_e     w_op;
  logic [31:0] w_imm;
  logic        w_bad;
  entry_t      w_entry;

  assign w_major = i_inst[6:0];
  assign w_f3    = i_inst[14:12];
  assign w_f7    = i_inst[31:25];
  assign w_imm_i = {{20{i_inst[31]}}, i_inst[31:20]};
  assign w_imm_s = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
  assign w_imm_b = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
  assign w_imm_j = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
  assign w_imm_u = {i_inst[31:12], 12'b0};

  always_comb begin
    w_op  = OP_NO_OP;
    w_imm = 32'b0;
    w_bad = 1'b0;
    case (w_major)
      7'b0110111: begin w_op = OP_LUI;   w_imm = w_imm_u; end
      7'b0010111: begin w_op = OP_AUIPC; w_imm = w_imm_u; end
      7'b1101111: begin w_op = OP_JAL;   w_imm = w_imm_j; end
      7'b1100111: begin
        w_op  = OP_JALR;
        w_imm = w_imm_i;
        w_bad = (w_f3 != 3'd0);
      end
      7'b1100011: begin
        w_imm = w_imm_b;
        case (w_f3)
          3'd0: w_op = OP_BEQ;
          3'd1: w_op = OP_BNE;
          3'd4: w_op = OP_BLT;
          3'd5: w_op = OP_BGE;
          3'd6: w_op = OP_BLTU;
          3'd7: w_op = OP_BGEU;
          default: w_bad = 1'b1;
        endcase
      end
      7'b0000011: begin
        w_imm = w_imm_i;
        case (w_f3)
          3'd0: w_op = OP_LB;
          3'd1: w_op = OP_LH;
          3'd2: w_op = OP_LW;
          3'd4: w_op = OP_LBU;
          3'd5: w_op = OP_LHU;
          default: w_bad = 1'b1;
        endcase
      end
      7'b0100011: begin
        w_imm = w_imm_s;
        case (w_f3)
          3'd0: w_op = OP_SB;
          3'd1: w_op = OP_SH;
          3'd2: w_op = OP_SW;
          default: w_bad = 1'b1;
        endcase
      end
      7'b0010011: begin
        w_imm = w_imm_i;
        case (w_f3)
          3'd0: w_op = OP_ADDI;
          3'd2: w_op = OP_SLTI;
          3'd3: w_op = OP_SLTIU;
          3'd4: w_op = OP_XORI;
          3'd6: w_op = OP_ORI;
          3'd7: w_op = OP_ANDI;
          3'd1: begin
            w_op  = OP_SLLI;
            w_bad = (w_f7 != 7'h00);
          end
          default: begin
            if (w_f7 == 7'h00)      w_op  = OP_SRLI;
            else if (w_f7 == 7'h20) w_op  = OP_SRAI;
            else                    w_bad = 1'b1;
          end
        endcase
      end
      7'b0110011: begin
        if (w_f7 == 7'h00) begin
          case (w_f3)
            3'd0: w_op = OP_ADD;
            3'd1: w_op = OP_SLL;
            3'd2: w_op = OP_SLT;
            3'd3: w_op = OP_SLTU;
            3'd4: w_op = OP_XOR;
            3'd5: w_op = OP_SRL;
            3'd6: w_op = OP_OR;
            default: w_op = OP_AND;
          endcase
        end else if (w_f7 == 7'h20 && w_f3 == 3'd0) begin
          w_op = OP_SUB;
        end else if (w_f7 == 7'h20 && w_f3 == 3'd5) begin
          w_op = OP_SRA;
`ifdef DECODE_QUEUE_MEXT_EN
        end else if (w_f7 == 7'h01) begin
          case (w_f3)
            3'd0: w_op = OP_MUL;
            3'd1: w_op = OP_MULH;
            3'd2: w_op = OP_MULHSU;
            3'd3: w_op = OP_MULHU;
            3'd4: w_op = OP_DIV;
            3'd5: w_op = OP_DIVU;
            3'd6: w_op = OP_REM;
            default: w_op = OP_REMU;
          endcase
`endif
        end else begin
          w_bad = 1'b1;
        end
      end
      7'b0001111: w_op = OP_NO_OP;
      7'b1110011: begin
        w_imm = w_imm_i;
        // Only ECALL/EBREAK are supported; any CSR form is rejected.
        if (w_f3 != 3'd0 || i_inst[19:15] != 5'd0 || i_inst[11:7] != 5'd0)
          w_bad = 1'b1;
        else if (i_inst[31:20] == 12'h000)
          w_op = OP_ECALL;
        else if (i_inst[31:20] == 12'h001)
          w_op = OP_EBREAK;
        else
          w_bad = 1'b1;
      end
      default: w_bad = 1'b1;
    endcase
  end

  always_comb begin
    w_entry         = '0;
    w_entry.op      = w_bad ? OP_NO_OP : w_op;
    w_entry.rs1     = i_inst[19:15];
    w_entry.rs2     = i_inst[24:20];
    w_entry.rd      = i_inst[11:7];
    w_entry.imm     = w_bad ? '0 : DW'(w_imm);
    w_entry.pc      = i_pc;
    w_entry.illegal = w_bad;
  end

  entry_t          r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            w_push;
  logic            w_pop;
  entry_t          w_head;

  assign o_inst_ready = (r_count != C_FULL);
  assign o_valid      = (r_count != '0);
  assign w_push       = i_inst_valid & o_inst_ready & i_clk_en;
  assign w_pop        = o_valid & i_ready & i_clk_en;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clk_en) begin
      if (i_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
        if (w_push && !w_pop)      r_count <= r_count + C_CNT_ONE;
        else if (!w_push && w_pop) r_count <= r_count - C_CNT_ONE;
      end
    end
  end

  // Storage needs no reset: entries are only observed through the count.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_push && !i_flush) r_mem[r_wr_ptr] <= w_entry;
  end

  assign w_head    = r_mem[r_rd_ptr];
  assign o_opcode  = o_valid ? w_head.op      : OP_NO_OP;
  assign o_rs1     = o_valid ? w_head.rs1     : 5'd0;
  assign o_rs2     = o_valid ? w_head.rs2     : 5'd0;
  assign o_rd      = o_valid ? w_head.rd      : 5'd0;
  assign o_imm     = o_valid ? w_head.imm     : '0;
  assign o_pc      = o_valid ? w_head.pc      : '0;
  assign o_illegal = o_valid ? w_head.illegal : 1'b0;
  assign o_count   = r_count;

endmodule

`default_nettype wire

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue: directed RV32I vectors with hand-computed decodes.
`default_nettype none

module tb_decode_queue;
  import decode_queue_pkg::*;

  localparam int DEPTH = 4;

  typedef struct packed {
    opcode_e     op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_en = 1'b1;
  logic        flush = 1'b0;
  logic        inst_valid = 1'b0;
  logic        ready = 1'b0;
  logic [31:0] inst = 32'b0;
  logic [31:0] pc = 32'b0;
  logic        inst_ready, valid, illegal;
  opcode_e     opcode;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm, o_pc;
  logic [2:0]  count;

  exp_t q[$];
  exp_t cur;
  bit   acc = 1'b0;
  bit   armed = 1'b0;
  int   pass_cnt = 0;
  int   total = 0;

  decode_queue #(.AW(32), .DW(32), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst), .i_clk_en(clk_en), .i_flush(flush),
    .i_inst_valid(inst_valid), .o_inst_ready(inst_ready), .i_inst(inst), .i_pc(pc),
    .o_valid(valid), .i_ready(ready), .o_opcode(opcode), .o_rs1(rs1), .o_rs2(rs2),
    .o_rd(rd), .o_imm(imm), .o_pc(o_pc), .o_illegal(illegal), .o_count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: actual %h required %h", nm, act, req);
  endtask

  // Monitor: compares the DUT against the model, then advances the model for the next edge.
  always @(negedge clk) begin
    exp_t head, e0;
    bit   push_m, pop_m;
    acc = 1'b0;
    if (rst) begin
      q.delete();
      armed = 1'b1;
    end else if (armed) begin
      check("count", 128'(count), 128'(q.size()));
      check("o_valid", 128'(valid), 128'(q.size() != 0));
      check("inst_ready", 128'(inst_ready), 128'(q.size() != DEPTH));
      head = {opcode, rs1, rs2, rd, imm, o_pc, illegal};
      if (q.size() != 0) begin
        check("head", 128'(head), 128'(q[0]));
      end else begin
        e0 = '0;
        e0.op = OP_NO_OP;
        check("empty_head", 128'(head), 128'(e0));
      end
      if (clk_en) begin
        if (flush) begin
          q.delete();
        end else begin
          push_m = inst_valid && (q.size() != DEPTH);
          pop_m  = (q.size() != 0) && ready;
          if (pop_m) void'(q.pop_front());
          if (push_m) begin
            q.push_back(cur);
            acc = 1'b1;
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_inst(input logic [31:0] w, input logic [31:0] p, input opcode_e op,
                          input logic [31:0] im, input logic il);
    inst    = w;
    pc      = p;
    cur.op  = op;
    cur.rs1 = w[19:15];
    cur.rs2 = w[24:20];
    cur.rd  = w[11:7];
    cur.imm = im;
    cur.pc  = p;
    cur.ill = il;
  endtask

  // Present an instruction and hold it until the model says it was accepted.
  task automatic send(input logic [31:0] w, input logic [31:0] p, input opcode_e op,
                      input logic [31:0] im, input logic il);
    int n = 0;
    set_inst(w, p, op, im, il);
    inst_valid = 1'b1;
    do begin
      @(posedge clk);
      n++;
    end while (!acc && n < 40);
    if (!acc) begin
      total++;
      $display("FAIL send_timeout: inst %h not accepted within %0d cycles", w, n);
    end
    #1;
  endtask

  initial begin
    tick(2);
    rst = 1'b0;

    // single instruction, one-cycle latency
    ready = 1'b1;
    send(32'h00500093, 32'h100, OP_ADDI, 32'h5, 1'b0);
    inst_valid = 1'b0;
    tick(3);

    // fill to full with consumer stalled, then drain in order
    ready = 1'b0;
    fork
      begin
        send(32'hFFF00113, 32'h200, OP_ADDI, 32'hFFFFFFFF, 1'b0);
        send(32'h123452B7, 32'h204, OP_LUI,  32'h12345000, 1'b0);
        send(32'h002081B3, 32'h208, OP_ADD,  32'h0, 1'b0);
        send(32'h40208233, 32'h20C, OP_SUB,  32'h0, 1'b0);
        send(32'h008000EF, 32'h210, OP_JAL,  32'h8, 1'b0);
      end
      begin
        tick(7);
        ready = 1'b1;
      end
    join
    inst_valid = 1'b0;
    tick(6);

    // store and unsigned branch immediates
    send(32'hFE20AE23, 32'h300, OP_SW,   32'hFFFFFFFC, 1'b0);
    send(32'hFE20ECE3, 32'h304, OP_BLTU, 32'hFFFFFFF8, 1'b0);
    inst_valid = 1'b0;
    tick(3);

    // flush with a simultaneous push and pop
    ready = 1'b0;
    send(32'h00812303, 32'h400, OP_LW,    32'h8, 1'b0);
    send(32'h00001397, 32'h404, OP_AUIPC, 32'h1000, 1'b0);
    send(32'h00000073, 32'h408, OP_ECALL, 32'h0, 1'b0);
    set_inst(32'h00500093, 32'h40C, OP_ADDI, 32'h5, 1'b0);
    ready = 1'b1;
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    inst_valid = 1'b0;
    tick(3);

    // M-extension and illegal encodings
`ifdef DECODE_QUEUE_MEXT_EN
    send(32'h022081B3, 32'h500, OP_MUL, 32'h0, 1'b0);
`else
    send(32'h022081B3, 32'h500, OP_NO_OP, 32'h0, 1'b1);
`endif
    send(32'h00000000, 32'h504, OP_NO_OP, 32'h0, 1'b1);
    send(32'h00003003, 32'h508, OP_NO_OP, 32'h0, 1'b1);
    send(32'h40009093, 32'h50C, OP_NO_OP, 32'h0, 1'b1);
    send(32'h0000000F, 32'h510, OP_NO_OP, 32'h0, 1'b0);
    inst_valid = 1'b0;
    tick(3);

    // clock enable low freezes everything
    ready = 1'b0;
    send(32'hFFF00113, 32'h600, OP_ADDI, 32'hFFFFFFFF, 1'b0);
    send(32'h123452B7, 32'h604, OP_LUI,  32'h12345000, 1'b0);
    set_inst(32'h00001397, 32'h608, OP_AUIPC, 32'h1000, 1'b0);
    clk_en = 1'b0;
    ready  = 1'b1;
    tick(3);
    clk_en = 1'b1;
    tick(1);
    inst_valid = 1'b0;
    tick(5);

    // reset mid-operation, then accept on the first edge after release
    ready = 1'b0;
    send(32'h002081B3, 32'h700, OP_ADD, 32'h0, 1'b0);
    send(32'h40208233, 32'h704, OP_SUB, 32'h0, 1'b0);
    inst_valid = 1'b0;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    ready = 1'b1;
    send(32'h00500093, 32'h708, OP_ADDI, 32'h5, 1'b0);
    inst_valid = 1'b0;
    tick(3);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

`default_nettype wire
